// File: rtl/cpu6_hazard_ctrl_if.sv
// Hazard-control bundle between the CPU6 pipeline datapath and the
// hazard controller: register indices, write enables, memory handshake,
// and the stall/flush/forward controls returned to the pipeline.
// The pipeline side uses modport master; the controller uses slave.

`ifndef CPU6_RFIDX_WIDTH
`define CPU6_RFIDX_WIDTH 5
`endif

interface cpu6_hazard_ctrl_if;
    logic [`CPU6_RFIDX_WIDTH-1:0] rs1D;
    logic [`CPU6_RFIDX_WIDTH-1:0] rs2D;
    logic [`CPU6_RFIDX_WIDTH-1:0] rs1E;
    logic [`CPU6_RFIDX_WIDTH-1:0] rs2E;
    logic [`CPU6_RFIDX_WIDTH-1:0] writeregE;
    logic [`CPU6_RFIDX_WIDTH-1:0] writeregM;
    logic [`CPU6_RFIDX_WIDTH-1:0] writeregW;
    logic                         regwriteE;
    logic                         regwriteM;
    logic                         regwriteW;
    logic                         memtoregE;
    logic                         branch_takenE;
    logic                         mem_reqM;
    logic                         mem_ackM;
    logic                         stallF;
    logic                         stallD;
    logic                         stallE;
    logic                         stallM;
    logic                         flushD;
    logic                         flushE;
    logic                         flushW;
    logic [1:0]                   fwd_aE;
    logic [1:0]                   fwd_bE;
    logic                         mem_err;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW, memtoregE,
        output branch_takenE, mem_reqM, mem_ackM,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        input  fwd_aE, fwd_bE, mem_err
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW, memtoregE,
        input  branch_takenE, mem_reqM, mem_ackM,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        output fwd_aE, fwd_bE, mem_err
    );
endinterface

// File: rtl/cpu6_hazard_ctrl.sv
// CPU6 pipeline hazard controller: data-memory wait/timeout FSM,
// load-use / RAW stall detection, branch flush and operand forwarding.
// Optional feature macro: CPU6_FORWARD_EN (defined -> E-stage forwarding
// from M/W; undefined -> no forwarding, stall on any E/M RAW hazard).
// All outputs are combinational from state, wait counter and inputs.

`ifndef CPU6_RFIDX_WIDTH
`define CPU6_RFIDX_WIDTH 5
`endif

module cpu6_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    cpu6_hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    localparam logic [7:0] TMO_CNT = 8'(MEM_TIMEOUT);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] wcnt_r;
    logic [7:0] wcnt_nxt_s;
    logic       mem_stall_s;
    logic       tmo_s;
    logic       data_hz_s;

    // Register index compare where x0 is hard-wired and never a hazard.
    function automatic logic idx_hit(
        input logic [`CPU6_RFIDX_WIDTH-1:0] dst,
        input logic [`CPU6_RFIDX_WIDTH-1:0] src
    );
        return (dst != '0) && (dst == src);
    endfunction

    // Operand source select: M result has priority over W result.
    function automatic logic [1:0] fwd_sel(
        input logic                         wr_m,
        input logic [`CPU6_RFIDX_WIDTH-1:0] dst_m,
        input logic                         wr_w,
        input logic [`CPU6_RFIDX_WIDTH-1:0] dst_w,
        input logic [`CPU6_RFIDX_WIDTH-1:0] src
    );
        if (wr_m && idx_hit(dst_m, src)) begin
            return 2'b10;
        end else if (wr_w && idx_hit(dst_w, src)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
            wcnt_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
        end
    end

    // Memory wait FSM: next state, counter, stall and timeout qualifiers.
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = wcnt_r;
        mem_stall_s = 1'b0;
        tmo_s       = 1'b0;
        if (reset) begin
            state_nxt_s = RUN;
            wcnt_nxt_s  = 8'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (hz.mem_reqM && !hz.mem_ackM) begin
                        state_nxt_s = MWAIT;
                        wcnt_nxt_s  = 8'd1;
                        mem_stall_s = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MWAIT: begin
                    // Ack wins over a coincident timeout.
                    if (hz.mem_ackM) begin
                        state_nxt_s = RUN;
                        wcnt_nxt_s  = 8'd0;
                    end else if (wcnt_r == TMO_CNT) begin
                        state_nxt_s = RUN;
                        wcnt_nxt_s  = 8'd0;
                        tmo_s       = 1'b1;
                    end else begin
                        wcnt_nxt_s  = wcnt_r + 8'd1;
                        mem_stall_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    wcnt_nxt_s  = 8'd0;
                end
            endcase
        end
    end

`ifdef CPU6_FORWARD_EN
    // Only a load in E cannot be forwarded in time; D must wait a cycle.
    always_comb begin
        data_hz_s = hz.memtoregE && hz.regwriteE &&
                    (idx_hit(hz.writeregE, hz.rs1D) || idx_hit(hz.writeregE, hz.rs2D));
    end
`else
    // Without forwarding any pending E or M write read by D must wait.
    always_comb begin
        data_hz_s = (hz.regwriteE &&
                     (idx_hit(hz.writeregE, hz.rs1D) || idx_hit(hz.writeregE, hz.rs2D))) ||
                    (hz.regwriteM &&
                     (idx_hit(hz.writeregM, hz.rs1D) || idx_hit(hz.writeregM, hz.rs2D)));
    end
`endif

    // Stall/flush/error outputs; memory stall freezes F..M and bubbles W.
    always_comb begin
        hz.stallF  = 1'b0;
        hz.stallD  = 1'b0;
        hz.stallE  = 1'b0;
        hz.stallM  = 1'b0;
        hz.flushD  = 1'b0;
        hz.flushE  = 1'b0;
        hz.flushW  = 1'b0;
        hz.mem_err = 1'b0;
        if (reset) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
            hz.flushW = 1'b1;
        end else if (mem_stall_s) begin
            // Branch held in the frozen E register; acts on release.
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.stallE = 1'b1;
            hz.stallM = 1'b1;
            hz.flushW = 1'b1;
        end else begin
            if (hz.branch_takenE) begin
                hz.flushD = 1'b1;
                hz.flushE = 1'b1;
            end else if (data_hz_s && !tmo_s) begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.flushE = 1'b1;
            end else begin
                hz.flushE = 1'b0;
            end
            // Abort: drop the failed access in M, pipeline keeps moving.
            if (tmo_s) begin
                hz.flushW  = 1'b1;
                hz.mem_err = 1'b1;
            end else begin
                hz.mem_err = 1'b0;
            end
        end
    end

`ifdef CPU6_FORWARD_EN
    // Forwarding muxes for both E-stage operands.
    always_comb begin
        if (reset) begin
            hz.fwd_aE = 2'b00;
            hz.fwd_bE = 2'b00;
        end else begin
            hz.fwd_aE = fwd_sel(hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW, hz.rs1E);
            hz.fwd_bE = fwd_sel(hz.regwriteM, hz.writeregM, hz.regwriteW, hz.writeregW, hz.rs2E);
        end
    end
`else
    // Forwarding disabled: operands always come from the register file.
    always_comb begin
        hz.fwd_aE = 2'b00;
        hz.fwd_bE = 2'b00;
    end
`endif

endmodule

// File: tb/tb_cpu6_hazard_ctrl.sv
// Scoreboard bench for cpu6_hazard_ctrl (MEM_TIMEOUT=4). The driver pushes
// the hand-computed output vector for each cycle; a negedge monitor pops
// and compares it with the DUT outputs.
// Vector bits: [11]stallF [10]stallD [9]stallE [8]stallM [7]flushD
// [6]flushE [5]flushW [4:3]fwd_aE [2:1]fwd_bE [0]mem_err.

module tb_cpu6_hazard_ctrl;

    localparam logic [11:0] V_NONE = 12'h000;
    localparam logic [11:0] V_MST  = 12'hF20;
    localparam logic [11:0] V_LU   = 12'hC40;
    localparam logic [11:0] V_BR   = 12'h0C0;
    localparam logic [11:0] V_RST  = 12'h0E0;
    localparam logic [11:0] V_TMO  = 12'h021;
`ifdef CPU6_FORWARD_EN
    localparam logic [11:0] V_FAM  = 12'h010;
    localparam logic [11:0] V_FAW  = 12'h008;
    localparam logic [11:0] V_FBM  = 12'h004;
    localparam logic [11:0] V_RAWD = 12'h010;
`else
    localparam logic [11:0] V_FAM  = 12'h000;
    localparam logic [11:0] V_FAW  = 12'h000;
    localparam logic [11:0] V_FBM  = 12'h000;
    localparam logic [11:0] V_RAWD = 12'hC40;
`endif

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [11:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    cpu6_hazard_ctrl_if hz();

    cpu6_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    wire [11:0] obs = {hz.stallF, hz.stallD, hz.stallE, hz.stallM,
                       hz.flushD, hz.flushE, hz.flushW,
                       hz.fwd_aE, hz.fwd_bE, hz.mem_err};

    // Monitor: compare DUT outputs against the oldest expected vector.
    always @(negedge clk) begin
        logic [11:0] e;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, obs, e);
            end
        end
    end

    task automatic clr();
        hz.rs1D = 5'd0; hz.rs2D = 5'd0; hz.rs1E = 5'd0; hz.rs2E = 5'd0;
        hz.writeregE = 5'd0; hz.writeregM = 5'd0; hz.writeregW = 5'd0;
        hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
        hz.memtoregE = 1'b0; hz.branch_takenE = 1'b0;
        hz.mem_reqM = 1'b0; hz.mem_ackM = 1'b0;
    endtask

    task automatic tick(input string nm, input logic [11:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        @(posedge clk);
        #1;
        tick("reset_a", V_RST);
        tick("reset_b", V_RST);
        reset = 1'b0;
        tick("idle", V_NONE);

        // Load-use
        hz.memtoregE = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd5; hz.rs1D = 5'd5;
        tick("loaduse_rs1", V_LU);
        hz.rs1D = 5'd0; hz.writeregE = 5'd0;
        tick("loaduse_x0", V_NONE);
        hz.writeregE = 5'd5; hz.rs2D = 5'd5;
        tick("loaduse_rs2", V_LU);
        hz.rs2D = 5'd0; hz.rs1D = 5'd5; hz.branch_takenE = 1'b1;
        tick("branch_over_lu", V_BR);
        clr();
        tick("idle2", V_NONE);

        // Memory wait, ack on fourth cycle
        hz.mem_reqM = 1'b1;
        tick("mwait_0", V_MST);
        tick("mwait_1", V_MST);
        tick("mwait_2", V_MST);
        hz.mem_ackM = 1'b1;
        tick("mwait_ack", V_NONE);
        clr();
        tick("mwait_run", V_NONE);

        // Timeout without ack
        hz.mem_reqM = 1'b1;
        tick("tmo_0", V_MST);
        tick("tmo_1", V_MST);
        tick("tmo_2", V_MST);
        tick("tmo_3", V_MST);
        tick("tmo_err", V_TMO);
        clr();
        tick("tmo_run", V_NONE);

        // Ack coinciding with timeout
        hz.mem_reqM = 1'b1;
        tick("ackto_0", V_MST);
        tick("ackto_1", V_MST);
        tick("ackto_2", V_MST);
        tick("ackto_3", V_MST);
        hz.mem_ackM = 1'b1;
        tick("ackto_ack", V_NONE);
        clr();
        tick("ackto_run", V_NONE);

        // Branch held during memory wait
        hz.mem_reqM = 1'b1; hz.branch_takenE = 1'b1;
        tick("brwait_0", V_MST);
        tick("brwait_1", V_MST);
        hz.mem_ackM = 1'b1;
        tick("brwait_rel", V_BR);
        clr();
        tick("brwait_run", V_NONE);

        // Forwarding
        hz.writeregM = 5'd7; hz.writeregW = 5'd7; hz.regwriteM = 1'b1; hz.regwriteW = 1'b1;
        hz.rs1E = 5'd7;
        tick("fwd_a_m", V_FAM);
        hz.regwriteM = 1'b0;
        tick("fwd_a_w", V_FAW);
        hz.regwriteM = 1'b1; hz.rs2E = 5'd7;
        tick("fwd_ab_m", V_FAM | V_FBM);
        hz.rs2E = 5'd0; hz.rs1D = 5'd7;
        tick("fwd_raw_d", V_RAWD);
        clr();
        hz.regwriteM = 1'b1; hz.regwriteW = 1'b1;
        tick("fwd_x0", V_NONE);
        clr();

        // Reset during memory wait at wcnt=2
        hz.mem_reqM = 1'b1;
        tick("rstw_0", V_MST);
        tick("rstw_1", V_MST);
        reset = 1'b1;
        tick("rstw_rst", V_RST);
        reset = 1'b0;
        clr();
        tick("rstw_run", V_NONE);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
